// File: rtl/ibex_irq_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ibex_irq_arbiter: registers interrupt sources, arbitrates by fixed priority |
// | and hands one frozen request at a time to the core controller.             |
// | Optional build macro IBEX_IRQ_SYNC_EN adds a two-flop input synchronizer.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ibex_irq_arbiter #(
  parameter bit NmiEdge = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        irq_software_i,
  input  logic        irq_timer_i,
  input  logic        irq_external_i,
  input  logic [14:0] irq_fast_i,
  input  logic        irq_nm_i,
  input  logic [17:0] mie_i,
  input  logic        mstatus_mie_i,
  input  logic        debug_mode_i,
  output logic        req_o,
  output logic [5:0]  cause_o,
  input  logic        ack_i,
  output logic [17:0] mip_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Source vector: [18] NMI, [17] software, [16] timer, [15] external, [14:0] fast
  logic [18:0] src_raw;
  logic [18:0] src;

  assign src_raw = {irq_nm_i, irq_software_i, irq_timer_i, irq_external_i, irq_fast_i};

`ifdef IBEX_IRQ_SYNC_EN
  logic [18:0] sync1_q;
  logic [18:0] sync2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= src_raw;
      sync2_q <= sync1_q;
    end
  end

  assign src = sync2_q;
`else
  assign src = src_raw;
`endif

  logic [17:0] irq_q;
  logic        nmi_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q <= '0;
      nmi_q <= 1'b0;
    end else begin
      irq_q <= src[17:0];
      nmi_q <= src[18];
    end
  end

  assign mip_o = irq_q;

  logic nmi_pend;
  logic nmi_clr;

  generate
    if (NmiEdge) begin : g_nmi_edge
      logic nmi_prev_q;
      logic nmi_pend_q;
      logic nmi_rise;

      assign nmi_rise = nmi_q & ~nmi_prev_q;
      // The rise itself counts as pending so edge NMIs see the same latency as levels
      assign nmi_pend = nmi_pend_q | nmi_rise;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          nmi_prev_q <= 1'b0;
          nmi_pend_q <= 1'b0;
        end else begin
          nmi_prev_q <= nmi_q;
          nmi_pend_q <= (nmi_pend_q & ~nmi_clr) | nmi_rise;
        end
      end
    end else begin : g_nmi_level
      logic unused_nmi_clr;
      assign unused_nmi_clr = nmi_clr;
      assign nmi_pend       = nmi_q;
    end
  endgenerate

  logic [17:0] irq_en;
  logic [18:0] elig;

  assign irq_en = irq_q & mie_i & {18{mstatus_mie_i & ~debug_mode_i}};
  assign elig   = {nmi_pend & ~debug_mode_i, irq_en};

  // Assignments run lowest priority first so the highest eligible source wins
  logic [18:0] win;
  logic [5:0]  win_cause;

  always_comb begin
    win       = '0;
    win_cause = 6'h00;
    if (elig[16]) begin
      win       = '0;
      win[16]   = 1'b1;
      win_cause = 6'h27;
    end
    if (elig[17]) begin
      win       = '0;
      win[17]   = 1'b1;
      win_cause = 6'h23;
    end
    if (elig[15]) begin
      win       = '0;
      win[15]   = 1'b1;
      win_cause = 6'h2B;
    end
    for (int i = 14; i >= 0; i--) begin
      if (elig[i]) begin
        win       = '0;
        win[i]    = 1'b1;
        win_cause = 6'h30 + 6'(i);
      end
    end
    if (elig[18]) begin
      win       = '0;
      win[18]   = 1'b1;
      win_cause = 6'h3F;
    end
  end

  state_e      state_q, state_d;
  logic        req_d;
  logic [5:0]  cause_d;
  logic [18:0] sel_q, sel_d;

  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    cause_d = cause_o;
    sel_d   = sel_q;
    nmi_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (|elig) begin
          state_d = REQ;
          req_d   = 1'b1;
          cause_d = win_cause;
          sel_d   = win;
        end
      end
      REQ: begin
        // Frozen request: only ack or loss of the chosen source ends it
        if (ack_i) begin
          state_d = HOLD;
          nmi_clr = sel_q[18];
        end else if (~|(sel_q & elig)) begin
          state_d = IDLE;
        end else begin
          req_d = 1'b1;
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      req_o   <= 1'b0;
      cause_o <= 6'h00;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      req_o   <= req_d;
      cause_o <= cause_d;
      sel_q   <= sel_d;
    end
  end

endmodule
`default_nettype wire
